// File: rtl/gate2_truth_checker.sv
// In-circuit sequencer for a 2-input gate: drives {A,B} through 00..11, samples Z
// after SETTLE cycles per vector and reports the per-vector failures, error count and pass.
module gate2_truth_checker #(
  parameter logic [3:0] TRUTH  = 4'b1000,
  parameter int         SETTLE = 2,
  parameter int         ERR_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Z,
  output logic             A,
  output logic             B,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] LAST_WAIT = 4'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       wait_q, wait_d;
  logic             a_d, b_d, busy_d, done_d, pass_d;
  logic [ERR_W-1:0] err_d;
  logic [3:0]       fail_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    err_d   = err_count;
    fail_d  = fail_vec;
    pass_d  = pass;
    a_d     = 1'b0;
    b_d     = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 2'd0;
          wait_d  = 4'd0;
          err_d   = '0;
          fail_d  = 4'b0000;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      DRIVE: begin
        busy_d     = 1'b1;
        {a_d, b_d} = idx_q;
        wait_d     = wait_q + 4'd1;
        if (wait_q == LAST_WAIT) begin
          if (Z != TRUTH[idx_q]) begin
            fail_d[idx_q] = 1'b1;
            err_d         = err_count + ERR_W'(1);
          end
          if (idx_q == 2'd3) begin
            // Outputs for the DONE cycle are registered here so done/pass need no Z path.
            state_d    = DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            pass_d     = (err_d == '0);
            {a_d, b_d} = 2'b00;
          end else begin
            idx_d      = idx_q + 2'd1;
            wait_d     = 4'd0;
            {a_d, b_d} = idx_q + 2'd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      wait_q    <= 4'd0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= 4'b0000;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      A         <= a_d;
      B         <= b_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_count <= err_d;
      fail_vec  <= fail_d;
    end
  end

endmodule

// File: tb/tb_gate2_truth_checker.sv
// Directed bench: AND-truth checker (SETTLE=2) against several modelled gates, plus an
// XOR-truth checker (SETTLE=1) exercised with start held high for back-to-back runs.
module tb_gate2_truth_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start0, start1, z0, z1, nand1, z1_stuck;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [3:0] fail0, fail1;
  logic [11:0] outs0, outs1;
  int         mode0;

  gate2_truth_checker #(.TRUTH(4'b1000), .SETTLE(2), .ERR_W(3)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .Z(z0), .A(a0), .B(b0), .busy(busy0),
    .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fail0));

  gate2_truth_checker #(.TRUTH(4'b0110), .SETTLE(1), .ERR_W(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .Z(z1), .A(a1), .B(b1), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1));

  // Gate models: 0 = AND built from two NANDs, 1 = stuck-at-0, 2 = stuck-at-1, 3 = XOR.
  assign nand1 = ~(a0 & b0);
  always_comb begin
    case (mode0)
      0:       z0 = ~(nand1 & nand1);
      1:       z0 = 1'b0;
      2:       z0 = 1'b1;
      default: z0 = a0 ^ b0;
    endcase
  end
  assign z1 = z1_stuck ? 1'b0 : (a1 ^ b1);

  assign outs0 = {a0, b0, busy0, done0, pass0, err0, fail0};
  assign outs1 = {a1, b1, busy1, done1, pass1, err1, fail1};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         mode;
    logic [3:0] fail;
    logic [2:0] err;
    logic       pass;
  } vec_t;

  vec_t tbl[5];

  // Called right after the edge that accepted start on dut0; walks the whole run.
  task automatic run_check0(input vec_t v);
    @(negedge clk);
    start0 = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 8) begin
        chk($sformatf("drive_c%0d", c), 32'({busy0, done0, a0, b0}), 32'({2'b10, 2'(c / 2)}));
      end else begin
        chk("done_cycle", 32'({busy0, done0, a0, b0}), 32'h4);
        chk("pass", 32'(pass0), 32'(v.pass));
        chk("err_count", 32'(err0), 32'(v.err));
        chk("fail_vec", 32'(fail0), 32'(v.fail));
      end
    end
    @(negedge clk);
    chk("done_one_cycle", 32'({busy0, done0}), 32'h0);
    chk("pass_hold", 32'(pass0), 32'(v.pass));
  endtask

  initial begin
    tbl[0] = '{mode: 0, fail: 4'b0000, err: 3'd0, pass: 1'b1};
    tbl[1] = '{mode: 1, fail: 4'b1000, err: 3'd1, pass: 1'b0};
    tbl[2] = '{mode: 2, fail: 4'b0111, err: 3'd3, pass: 1'b0};
    tbl[3] = '{mode: 3, fail: 4'b1110, err: 3'd3, pass: 1'b0};
    tbl[4] = '{mode: 0, fail: 4'b0000, err: 3'd0, pass: 1'b1};

    rst = 1'b1; start0 = 1'b1; start1 = 1'b1; mode0 = 0; z1_stuck = 1'b1;

    // Reset held with start high: nothing may launch.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_dut0", 32'(outs0), 32'h0);
      chk("reset_dut1", 32'(outs1), 32'h0);
    end
    rst = 1'b0;
    start1 = 1'b0;
    @(posedge clk);
    run_check0(tbl[0]);

    for (int i = 0; i < 5; i++) begin
      mode0 = tbl[i].mode;
      start0 = 1'b1;
      @(posedge clk);
      run_check0(tbl[i]);
    end

    // Mid-run reset while vector 2 is on the pins.
    mode0 = 0;
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_vec2", 32'({busy0, a0, b0}), 32'h6);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset", 32'(outs0), 32'h0);
    rst = 1'b0;
    begin
      int dn = 0;
      repeat (12) begin
        @(negedge clk);
        if (done0 || busy0) dn++;
      end
      chk("no_done_after_reset", 32'(dn), 32'h0);
    end
    mode0 = tbl[1].mode;
    start0 = 1'b1;
    @(posedge clk);
    run_check0(tbl[1]);

    // Back-to-back runs with start held: done every 6 cycles, results clear at each T0.
    start1 = 1'b1;
    for (int e = 0; e < 36; e++) begin
      @(negedge clk);
      if (e == 29) start1 = 1'b0;
      chk($sformatf("b2b_done_e%0d", e), 32'(done1), 32'((e % 6 == 4) && (e < 30)));
      if ((e % 6 == 0) && (e < 30))
        chk($sformatf("b2b_clear_e%0d", e), 32'({busy1, err1, fail1}), 32'({1'b1, 3'd0, 4'b0000}));
      if ((e % 6 == 4) && (e < 30))
        chk($sformatf("b2b_result_e%0d", e), 32'({pass1, err1, fail1}), 32'({1'b0, 3'd2, 4'b0110}));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
